// File: rtl/gb_pkg.sv
// gb_pkg: shared types and default constants for the gb_param global buffer.
//   gb_state_t    - buffer FSM states
//   gb_op_t       - operation latched on acceptance
//   GB_ACCESS_LAT - default accept-to-done latency
//   GB_PSUM_W     - default accumulate lane width
package gb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_DONE   = 2'd3
  } gb_state_t;

  typedef enum logic [1:0] {
    OP_RD     = 2'd0,
    OP_WR_MEM = 2'd1,
    OP_WR_PE  = 2'd2,
    OP_CLR    = 2'd3
  } gb_op_t;

  localparam int unsigned GB_ACCESS_LAT = 10;
  localparam int unsigned GB_PSUM_W     = 16;

endpackage

// File: rtl/gb_param_if.sv
// gb_param_if: request/address/data bundle of the global buffer.
//   master - requester side (drives requests, addresses, write data)
//   slave  - buffer side (drives read data, done, busy, addr_err)
interface gb_param_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned AW     = 9,
  parameter int unsigned NUM_PE = 8
);

  logic                     init;
  logic                     write_mem_to_GB;
  logic                     write_PE_to_GB;
  logic                     read_GB;
  logic                     acc_mode;
  logic [AW-1:0]            addr_write;
  logic [AW-1:0]            addr_mem;
  logic [AW-1:0]            addr_psum;
  logic [NUM_PE*AW-1:0]     addr_PE;
  logic [DATA_W-1:0]        data_in_mem;
  logic [DATA_W-1:0]        data_in_PE;
  logic [DATA_W-1:0]        data_out_mem;
  logic [DATA_W-1:0]        data_out_psum;
  logic [NUM_PE*DATA_W-1:0] data_out_PE;
  logic                     done;
  logic                     busy;
  logic                     addr_err;

  modport master (
    output init, write_mem_to_GB, write_PE_to_GB, read_GB, acc_mode,
    output addr_write, addr_mem, addr_psum, addr_PE, data_in_mem, data_in_PE,
    input  data_out_mem, data_out_psum, data_out_PE, done, busy, addr_err
  );

  modport slave (
    input  init, write_mem_to_GB, write_PE_to_GB, read_GB, acc_mode,
    input  addr_write, addr_mem, addr_psum, addr_PE, data_in_mem, data_in_PE,
    output data_out_mem, data_out_psum, data_out_PE, done, busy, addr_err
  );

endinterface

// File: rtl/gb_lane_adder.sv
// gb_lane_adder: DATA_W-wide adder split into PSUM_W lanes; each lane wraps
// modulo 2^PSUM_W and no carry crosses a lane boundary.
//   a_i, b_i - operands
//   sum_o    - lane-wise sum (combinational)
module gb_lane_adder #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PSUM_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o
);

  localparam int unsigned LANES = DATA_W / PSUM_W;

  always_comb begin
    sum_o = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      sum_o[l*PSUM_W +: PSUM_W] = a_i[l*PSUM_W +: PSUM_W] + b_i[l*PSUM_W +: PSUM_W];
    end
  end

endmodule

// File: rtl/gb_param.sv
// gb_param: global buffer between off-chip memory and the PE array. One op in
// flight at a time; reads/writes take ACCESS_LAT cycles, init clears every
// word one per cycle; each op ends with a one-cycle done pulse.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - gb_param_if.slave: requests, addresses, write data in;
//              registered read data, done, busy, addr_err out
// Build option: define GB_PSUM_ACC_EN to make PE writes with acc_mode=1
// accumulate lane-wise into the stored word.
module gb_param
  import gb_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned AW         = $clog2(DEPTH),
  parameter int unsigned NUM_PE     = 8,
  parameter int unsigned ACCESS_LAT = GB_ACCESS_LAT,
  parameter int unsigned PSUM_W     = GB_PSUM_W
) (
  input logic       clk,
  input logic       rst,
  gb_param_if.slave bus
);

  localparam int unsigned   CW        = 4;
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(ACCESS_LAT - 1);

  if ((DATA_W % PSUM_W) != 0 || ACCESS_LAT < 1 || ACCESS_LAT > 15) begin : g_bad_cfg
    $error("gb_param: unsupported DATA_W/PSUM_W/ACCESS_LAT combination");
  end

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_EXT;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  gb_state_t                state_q, state_d;
  gb_op_t                   op_q, op_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [AW-1:0]            clr_addr_q, clr_addr_d;
  logic [AW-1:0]            addr_write_q, addr_write_d;
  logic [AW-1:0]            addr_mem_q, addr_mem_d;
  logic [AW-1:0]            addr_psum_q, addr_psum_d;
  logic [NUM_PE*AW-1:0]     addr_pe_q, addr_pe_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic                     acc_q, acc_d;
  logic [DATA_W-1:0]        data_out_mem_q, data_out_mem_d;
  logic [DATA_W-1:0]        data_out_psum_q, data_out_psum_d;
  logic [NUM_PE*DATA_W-1:0] data_out_pe_q, data_out_pe_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     addr_err_q, addr_err_d;

  logic                 req_vld_c;
  gb_op_t               req_op_c;
  logic [DATA_W-1:0]    req_wdata_c;
  gb_op_t               cur_op_c;
  logic [AW-1:0]        cur_addr_write_c, cur_addr_mem_c, cur_addr_psum_c;
  logic [NUM_PE*AW-1:0] cur_addr_pe_c;
  logic [DATA_W-1:0]    cur_wdata_c, wr_word_c;
  logic                 cur_acc_c;
  logic                 commit_c;
  logic                 mem_we_c;
  logic [AW-1:0]        mem_waddr_c;
  logic [DATA_W-1:0]    mem_wdata_c;

  // Fixed-priority request decode: init > mem write > PE write > read.
  always_comb begin
    req_vld_c   = bus.init | bus.write_mem_to_GB | bus.write_PE_to_GB | bus.read_GB;
    req_op_c    = OP_RD;
    req_wdata_c = bus.data_in_PE;
    if (bus.init) begin
      req_op_c = OP_CLR;
    end else if (bus.write_mem_to_GB) begin
      req_op_c    = OP_WR_MEM;
      req_wdata_c = bus.data_in_mem;
    end else if (bus.write_PE_to_GB) begin
      req_op_c = OP_WR_PE;
    end
  end

  // Op seen by the commit logic: live request in IDLE (ACCESS_LAT==1 commits
  // on the accept edge), latched copy afterwards.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_op_c         = req_op_c;
      cur_addr_write_c = bus.addr_write;
      cur_addr_mem_c   = bus.addr_mem;
      cur_addr_psum_c  = bus.addr_psum;
      cur_addr_pe_c    = bus.addr_PE;
      cur_wdata_c      = req_wdata_c;
      cur_acc_c        = bus.acc_mode;
    end else begin
      cur_op_c         = op_q;
      cur_addr_write_c = addr_write_q;
      cur_addr_mem_c   = addr_mem_q;
      cur_addr_psum_c  = addr_psum_q;
      cur_addr_pe_c    = addr_pe_q;
      cur_wdata_c      = wdata_q;
      cur_acc_c        = acc_q;
    end
  end

`ifdef GB_PSUM_ACC_EN
  // Old word is read from the array in the same cycle the sum is committed.
  logic [DATA_W-1:0] old_word_c, acc_sum_c;
  assign old_word_c = in_range(cur_addr_write_c) ? mem[cur_addr_write_c] : '0;

  gb_lane_adder #(
    .DATA_W (DATA_W),
    .PSUM_W (PSUM_W)
  ) u_lane_adder (
    .a_i   (old_word_c),
    .b_i   (cur_wdata_c),
    .sum_o (acc_sum_c)
  );

  assign wr_word_c = (cur_op_c == OP_WR_PE && cur_acc_c) ? acc_sum_c : cur_wdata_c;
`else
  logic unused_acc_c;
  assign unused_acc_c = cur_acc_c;
  assign wr_word_c    = cur_wdata_c;
`endif

  // Next-state, latch and output computation.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    cnt_d           = cnt_q;
    clr_addr_d      = clr_addr_q;
    addr_write_d    = addr_write_q;
    addr_mem_d      = addr_mem_q;
    addr_psum_d     = addr_psum_q;
    addr_pe_d       = addr_pe_q;
    wdata_d         = wdata_q;
    acc_d           = acc_q;
    data_out_mem_d  = data_out_mem_q;
    data_out_psum_d = data_out_psum_q;
    data_out_pe_d   = data_out_pe_q;
    done_d          = 1'b0;
    addr_err_d      = 1'b0;
    commit_c        = 1'b0;
    mem_we_c        = 1'b0;
    mem_waddr_c     = clr_addr_q;
    mem_wdata_c     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_vld_c) begin
          op_d         = req_op_c;
          addr_write_d = bus.addr_write;
          addr_mem_d   = bus.addr_mem;
          addr_psum_d  = bus.addr_psum;
          addr_pe_d    = bus.addr_PE;
          wdata_d      = req_wdata_c;
          acc_d        = bus.acc_mode;
          cnt_d        = CW'(1);
          if (req_op_c == OP_CLR) begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
          end else if (ACCESS_LAT == 1) begin
            commit_c = 1'b1;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) commit_c = 1'b1;
      end
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = clr_addr_q;
        clr_addr_d  = clr_addr_q + AW'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Commit edge: writes land in the array, reads load the output registers.
    if (commit_c) begin
      state_d = ST_DONE;
      done_d  = 1'b1;
      if (cur_op_c == OP_RD) begin
        data_out_mem_d  = in_range(cur_addr_mem_c) ? mem[cur_addr_mem_c] : '0;
        data_out_psum_d = in_range(cur_addr_psum_c) ? mem[cur_addr_psum_c] : '0;
        addr_err_d      = ~in_range(cur_addr_mem_c) | ~in_range(cur_addr_psum_c);
        for (int i = 0; i < NUM_PE; i++) begin
          data_out_pe_d[i*DATA_W +: DATA_W] = in_range(cur_addr_pe_c[i*AW +: AW]) ?
                                              mem[cur_addr_pe_c[i*AW +: AW]] : '0;
          addr_err_d = addr_err_d | ~in_range(cur_addr_pe_c[i*AW +: AW]);
        end
      end else begin
        addr_err_d  = ~in_range(cur_addr_write_c);
        mem_we_c    = in_range(cur_addr_write_c);
        mem_waddr_c = cur_addr_write_c;
        mem_wdata_c = wr_word_c;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Array storage carries no reset; contents are defined only after init.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      op_q            <= OP_RD;
      cnt_q           <= '0;
      clr_addr_q      <= '0;
      addr_write_q    <= '0;
      addr_mem_q      <= '0;
      addr_psum_q     <= '0;
      addr_pe_q       <= '0;
      wdata_q         <= '0;
      acc_q           <= 1'b0;
      data_out_mem_q  <= '0;
      data_out_psum_q <= '0;
      data_out_pe_q   <= '0;
      done_q          <= 1'b0;
      busy_q          <= 1'b0;
      addr_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      cnt_q           <= cnt_d;
      clr_addr_q      <= clr_addr_d;
      addr_write_q    <= addr_write_d;
      addr_mem_q      <= addr_mem_d;
      addr_psum_q     <= addr_psum_d;
      addr_pe_q       <= addr_pe_d;
      wdata_q         <= wdata_d;
      acc_q           <= acc_d;
      data_out_mem_q  <= data_out_mem_d;
      data_out_psum_q <= data_out_psum_d;
      data_out_pe_q   <= data_out_pe_d;
      done_q          <= done_d;
      busy_q          <= busy_d;
      addr_err_q      <= addr_err_d;
    end
  end

  assign bus.data_out_mem  = data_out_mem_q;
  assign bus.data_out_psum = data_out_psum_q;
  assign bus.data_out_PE   = data_out_pe_q;
  assign bus.done          = done_q;
  assign bus.busy          = busy_q;
  assign bus.addr_err      = addr_err_q;

endmodule

// File: tb/tb_gb_param.sv
// tb_gb_param: self-checking bench for gb_param. A non-power-of-two DEPTH is
// used so that out-of-range addresses are representable on the AW-bit buses.
module tb_gb_param;
  import gb_pkg::*;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned DEPTH      = 500;
  localparam int unsigned AW         = 9;
  localparam int unsigned NUM_PE     = 8;
  localparam int unsigned ACCESS_LAT = 10;
  localparam int unsigned PSUM_W     = 16;
  localparam int          BUDGET     = 2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gb_param_if #(.DATA_W(DATA_W), .AW(AW), .NUM_PE(NUM_PE)) bus ();

  gb_param #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .NUM_PE     (NUM_PE),
    .ACCESS_LAT (ACCESS_LAT),
    .PSUM_W     (PSUM_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: word array plus the values the read ports must show.
  logic [DATA_W-1:0]        ref_mem [DEPTH];
  logic [DATA_W-1:0]        exp_mem_out, exp_psum_out;
  logic [NUM_PE*DATA_W-1:0] exp_pe_out;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_read(input logic [AW-1:0] a);
    return (a < DEPTH) ? ref_mem[a] : '0;
  endfunction

`ifdef GB_PSUM_ACC_EN
  function automatic logic [DATA_W-1:0] lane_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r = '0;
    for (int l = 0; l < int'(DATA_W / PSUM_W); l++) begin
      int unsigned s = (32'(a[l*PSUM_W +: PSUM_W]) + 32'(b[l*PSUM_W +: PSUM_W])) % 65536;
      r[l*PSUM_W +: PSUM_W] = 16'(s);
    end
    return r;
  endfunction
`endif

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(7, 0) == 0) return AW'($urandom_range(511, DEPTH));
    return AW'($urandom_range(DEPTH - 1, 0));
  endfunction

  // Drop all requests and scramble the operand inputs.
  task automatic clear_reqs();
    bus.init            = 1'b0;
    bus.write_mem_to_GB = 1'b0;
    bus.write_PE_to_GB  = 1'b0;
    bus.read_GB         = 1'b0;
    bus.acc_mode        = 1'($urandom_range(1, 0));
    bus.addr_write      = AW'($urandom);
    bus.addr_mem        = AW'($urandom);
    bus.addr_psum       = AW'($urandom);
    for (int i = 0; i < int'(NUM_PE); i++) bus.addr_PE[i*AW +: AW] = AW'($urandom);
    bus.data_in_mem     = {$urandom, $urandom};
    bus.data_in_PE      = {$urandom, $urandom};
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_mem_out"}, bus.data_out_mem, exp_mem_out);
    check({tag, "_psum_out"}, bus.data_out_psum, exp_psum_out);
    check({tag, "_pe_out"}, bus.data_out_PE, exp_pe_out);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mem_out"}, bus.data_out_mem, '0);
    check({tag, "_psum_out"}, bus.data_out_psum, '0);
    check({tag, "_pe_out"}, bus.data_out_PE, '0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_err"}, bus.addr_err, 1'b0);
  endtask

  // Requests are already on the bus in an IDLE cycle; count edges to done.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat = -1;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk); #1;
      if (n == 1) clear_reqs();
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic to_idle(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  task automatic do_write(input string tag, input bit pe, input logic [AW-1:0] a,
                          input logic [DATA_W-1:0] d, input bit acc);
    bit use_acc = 1'b0;
    bus.write_mem_to_GB = !pe;
    bus.write_PE_to_GB  = pe;
    bus.addr_write      = a;
    bus.acc_mode        = acc;
    if (pe) bus.data_in_PE = d;
    else    bus.data_in_mem = d;
    wait_done(tag, ACCESS_LAT);
    check({tag, "_err"}, bus.addr_err, (a >= DEPTH));
`ifdef GB_PSUM_ACC_EN
    use_acc = pe && acc;
`endif
    if (a < DEPTH) begin
`ifdef GB_PSUM_ACC_EN
      if (use_acc) ref_mem[a] = lane_add(ref_mem[a], d);
      else         ref_mem[a] = d;
`else
      ref_mem[a] = use_acc ? ref_mem[a] : d;
`endif
    end
    check_outputs(tag);
    to_idle(tag);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] am, input logic [AW-1:0] ap,
                         input logic [NUM_PE*AW-1:0] pa);
    bit err;
    bus.read_GB   = 1'b1;
    bus.addr_mem  = am;
    bus.addr_psum = ap;
    bus.addr_PE   = pa;
    wait_done(tag, ACCESS_LAT);
    err          = (am >= DEPTH) || (ap >= DEPTH);
    exp_mem_out  = ref_read(am);
    exp_psum_out = ref_read(ap);
    for (int i = 0; i < int'(NUM_PE); i++) begin
      exp_pe_out[i*DATA_W +: DATA_W] = ref_read(pa[i*AW +: AW]);
      if (pa[i*AW +: AW] >= DEPTH) err = 1'b1;
    end
    check({tag, "_err"}, bus.addr_err, err);
    check_outputs(tag);
    to_idle(tag);
  endtask

  initial begin
    logic [NUM_PE*AW-1:0] pa;
    logic [32:0]          done_seen;
    logic [32:0]          done_exp;
    int                   first_done, second_done;
    logic [DATA_W-1:0]    acc_exp;

    rst = 1'b1;
    clear_reqs();
    exp_mem_out  = '0;
    exp_psum_out = '0;
    exp_pe_out   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Clear the whole array: one IDLE cycle, DEPTH clear cycles, then done.
    bus.init = 1'b1;
    wait_done("init", DEPTH + 1);
    check("init_err", bus.addr_err, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    to_idle("init");

    // Memory write then broadcast read of the same word.
    do_write("wr3", 1'b0, AW'(3), 64'h1122334455667788, 1'b0);
    for (int i = 0; i < int'(NUM_PE); i++) pa[i*AW +: AW] = AW'(3);
    do_read("rd3", AW'(4), AW'(DEPTH - 1), pa);
    check("rd3_pe_const", bus.data_out_PE, {NUM_PE{64'h1122334455667788}});
    check("rd3_mem_zero", bus.data_out_mem, 64'h0);

    // Write and read requested together: write first, then the read sees it.
    bus.write_mem_to_GB = 1'b1;
    bus.read_GB         = 1'b1;
    bus.addr_write      = AW'(7);
    bus.data_in_mem     = 64'hCAFE_F00D_DEAD_BEEF;
    bus.addr_mem        = AW'(7);
    bus.addr_psum       = AW'(7);
    for (int i = 0; i < int'(NUM_PE); i++) bus.addr_PE[i*AW +: AW] = AW'(7);
    first_done  = -1;
    second_done = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == 1) bus.write_mem_to_GB = 1'b0;
      if (bus.done === 1'b1) begin
        if (first_done < 0) first_done = n;
        else begin
          second_done = n;
          break;
        end
      end
    end
    clear_reqs();
    check("wr_rd_first_done", first_done, ACCESS_LAT);
    check("wr_rd_second_done", second_done, 2 * ACCESS_LAT + 1);
    ref_mem[7]   = 64'hCAFE_F00D_DEAD_BEEF;
    exp_mem_out  = ref_mem[7];
    exp_psum_out = ref_mem[7];
    exp_pe_out   = {NUM_PE{ref_mem[7]}};
    check_outputs("wr_rd");
    to_idle("wr_rd");

    // Held read request repeats every ACCESS_LAT+1 cycles.
    bus.read_GB   = 1'b1;
    bus.addr_mem  = AW'(3);
    bus.addr_psum = AW'(7);
    for (int i = 0; i < int'(NUM_PE); i++) bus.addr_PE[i*AW +: AW] = AW'(i);
    done_seen = '0;
    for (int n = 1; n <= 33; n++) begin
      @(posedge clk); #1;
      done_seen[n-1] = bus.done;
    end
    clear_reqs();
    done_exp = '0;
    done_exp[9]  = 1'b1;
    done_exp[20] = 1'b1;
    done_exp[31] = 1'b1;
    check("held_read_done_pattern", done_seen, done_exp);
    exp_mem_out  = ref_mem[3];
    exp_psum_out = ref_mem[7];
    for (int i = 0; i < int'(NUM_PE); i++) exp_pe_out[i*DATA_W +: DATA_W] = ref_mem[i];
    check_outputs("held_read");

    // Out-of-range write is dropped and flagged; out-of-range read port gives 0.
    do_write("wr_oob", 1'b0, AW'(505), 64'h0BAD_0BAD_0BAD_0BAD, 1'b0);
    for (int i = 0; i < int'(NUM_PE); i++) pa[i*AW +: AW] = (i == 2) ? AW'(511) : AW'(3);
    do_read("rd_oob", AW'(505), AW'(3), pa);
    check("rd_oob_mem_zero", bus.data_out_mem, 64'h0);

    // Accumulating PE write.
    do_write("acc_base", 1'b0, AW'(20), 64'hFFFF_0001_0002_0003, 1'b0);
    do_write("acc_pe", 1'b1, AW'(20), 64'h0001_0001_0001_0001, 1'b1);
    do_read("acc_rd", AW'(20), AW'(20), {NUM_PE{AW'(20)}});
`ifdef GB_PSUM_ACC_EN
    acc_exp = 64'h0000_0002_0003_0004;
`else
    acc_exp = 64'h0001_0001_0001_0001;
`endif
    check("acc_word", bus.data_out_mem, acc_exp);

    // Random mix of operations against the model.
    for (int k = 0; k < 40; k++) begin
      int unsigned kind = $urandom_range(2, 0);
      if (kind == 0) begin
        do_write("rnd_wr_mem", 1'b0, rand_addr(), {$urandom, $urandom}, 1'($urandom_range(1, 0)));
      end else if (kind == 1) begin
        do_write("rnd_wr_pe", 1'b1, rand_addr(), {$urandom, $urandom}, 1'($urandom_range(1, 0)));
      end else begin
        for (int i = 0; i < int'(NUM_PE); i++) pa[i*AW +: AW] = rand_addr();
        do_read("rnd_rd", rand_addr(), rand_addr(), pa);
      end
    end

    // Reset five cycles into a write: outputs clear, write never lands.
    bus.write_mem_to_GB = 1'b1;
    bus.addr_write      = AW'(3);
    bus.data_in_mem     = 64'h5555_AAAA_5555_AAAA;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      if (n == 1) clear_reqs();
    end
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_mem_out  = '0;
    exp_psum_out = '0;
    exp_pe_out   = '0;
    for (int i = 0; i < int'(NUM_PE); i++) pa[i*AW +: AW] = AW'(3);
    do_read("after_rst", AW'(3), AW'(7), pa);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
